// File: rtl/jt900h_pkg.sv
// Shared definitions for the jt900h instruction prefetcher.
//   state_t : prefetch FSM encoding (FLUSH after reset/jump, FETCH otherwise)
//   FW      : width of the per-cycle retired-byte count (0..4)
package jt900h_pkg;

   typedef enum logic [0:0] {
      FLUSH = 1'b0,
      FETCH = 1'b1
   } state_t;

   localparam int unsigned FW = 3;

endpackage

// File: rtl/jt900h_bytefifo.sv
// Circular byte queue for the jt900h prefetcher.
// Accepts 0..2 bytes per cycle (low byte first) and retires 0..4 bytes per cycle.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   cen        clock enable; nothing changes while low
//   flush      empty the queue and zero both pointers (wins over wr/rd)
//   wr_n       bytes to append this cycle (0..2), taken from wr_data[7:0] then [15:8]
//   rd_n       bytes to retire this cycle (0..4), must not exceed count
//   dout       head bytes 0..3, byte0 in [7:0]; bytes past count read as 0
//   count      number of valid bytes (0..QD)
module jt900h_bytefifo #(
   parameter int unsigned QD = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       cen,
   input  logic                       flush,
   input  logic [1:0]                 wr_n,
   input  logic [15:0]                wr_data,
   input  logic [2:0]                 rd_n,
   output logic [31:0]                dout,
   output logic [$clog2(QD+1)-1:0]    count
);

   localparam int unsigned PW = $clog2(QD);
   localparam int unsigned CW = $clog2(QD + 1);

   logic [7:0]    mem [QD];
   logic [PW-1:0] rd_ptr_q, wr_ptr_q;
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else if (cen) begin
         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
         end else begin
            rd_ptr_q <= rd_ptr_q + PW'(rd_n);
            wr_ptr_q <= wr_ptr_q + PW'(wr_n);
            cnt_q    <= cnt_q - CW'(rd_n) + CW'(wr_n);
         end
      end
   end

   // Storage needs no reset: bytes beyond count are masked on the read side.
   always_ff @(posedge clk) begin
      if (cen && !flush) begin
         if (wr_n != 2'd0) mem[wr_ptr_q] <= wr_data[7:0];
         if (wr_n == 2'd2) mem[wr_ptr_q + PW'(1)] <= wr_data[15:8];
      end
   end

   always_comb begin
      dout = '0;
      for (int i = 0; i < 4; i++) begin
         if (CW'(i) < cnt_q) dout[8*i +: 8] = mem[rd_ptr_q + PW'(i)];
      end
   end

   assign count = cnt_q;

endmodule

// File: rtl/jt900h_prefetch.sv
// Instruction prefetcher: reads aligned 16-bit words ahead of execution into a byte
// queue and presents the next four opcode bytes to the decoder.
// Optional build macro JT900H_PREFETCH_CHK_EN adds a sticky underrun flag on ovf.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cen                 clock enable
//   jmp, jmp_addr       flush queue and restart fetch at jmp_addr (may be odd)
//   ram_addr, ram_cs    even read address and read request
//   ram_dout, ram_ok    read data ([7:0] = even byte) and its one-cycle valid strobe
//   fetched             bytes retired by the consumer this cycle (0..4)
//   dout, avail, pc     head bytes, valid count min(count,4), address of dout[7:0]
//   ovf                 underrun flag (0 unless JT900H_PREFETCH_CHK_EN)
module jt900h_prefetch
   import jt900h_pkg::*;
#(
   parameter int unsigned QD = 8,
   parameter int unsigned AW = 24
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cen,
   input  logic          jmp,
   input  logic [AW-1:0] jmp_addr,
   output logic [AW-1:0] ram_addr,
   output logic          ram_cs,
   input  logic [15:0]   ram_dout,
   input  logic          ram_ok,
   input  logic [FW-1:0] fetched,
   output logic [31:0]   dout,
   output logic [2:0]    avail,
   output logic [AW-1:0] pc,
   output logic          ovf
);

   localparam int unsigned CW = $clog2(QD + 1);

   state_t        state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW-1:0] pc_q, pc_d;
   logic          skip_q, skip_d;

   logic [CW-1:0] count, ret_n, free_after;
   logic          take;
   logic [1:0]    wr_n;
   logic [2:0]    rd_n;
   logic [15:0]   wr_data;

   // Retire no more than is actually queued.
   assign ret_n      = (CW'(fetched) > count) ? count : CW'(fetched);
   // Requesting only with two free slots keeps count from ever exceeding QD.
   assign free_after = CW'(QD) - (count - ret_n);
   assign ram_cs     = (state_q == FETCH) && (free_after >= CW'(2));
   assign take       = ram_cs && ram_ok && !jmp;

   // After an odd jump the even byte of the first word is not part of the program stream.
   assign wr_n    = take ? (skip_q ? 2'd1 : 2'd2) : 2'd0;
   assign wr_data = skip_q ? {8'h00, ram_dout[15:8]} : ram_dout;
   assign rd_n    = jmp ? 3'd0 : ret_n[2:0];

   jt900h_bytefifo #(
      .QD (QD)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .cen     (cen),
      .flush   (jmp),
      .wr_n    (wr_n),
      .wr_data (wr_data),
      .rd_n    (rd_n),
      .dout    (dout),
      .count   (count)
   );

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      skip_d  = skip_q;
      pc_d    = pc_q;
      if (jmp) begin
         state_d = FLUSH;
         addr_d  = {jmp_addr[AW-1:1], 1'b0};
         skip_d  = jmp_addr[0];
         pc_d    = jmp_addr;
      end else begin
         state_d = FETCH;
         pc_d    = pc_q + AW'(ret_n);
         if (take) begin
            addr_d = addr_q + AW'(2);
            skip_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FLUSH;
         addr_q  <= '0;
         skip_q  <= 1'b0;
         pc_q    <= '0;
      end else if (cen) begin
         state_q <= state_d;
         addr_q  <= addr_d;
         skip_q  <= skip_d;
         pc_q    <= pc_d;
      end
   end

   assign ram_addr = addr_q;
   assign pc       = pc_q;
   assign avail    = (count >= CW'(4)) ? 3'd4 : count[2:0];

`ifdef JT900H_PREFETCH_CHK_EN
   logic ovf_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (cen && !jmp && (CW'(fetched) > count)) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_jt900h_prefetch.sv
// Bench for jt900h_prefetch: directed cycles push expected output snapshots and expected
// accepted read addresses into queues; monitors on the falling edge pop and compare.
module tb_jt900h_prefetch;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cen = 1'b1;
   logic        jmp = 1'b0;
   logic [23:0] jmp_addr = '0;
   logic [23:0] ram_addr;
   logic        ram_cs;
   logic [15:0] ram_dout = '0;
   logic        ram_ok = 1'b0;
   logic [2:0]  fetched = '0;
   logic [31:0] dout;
   logic [2:0]  avail;
   logic [23:0] pc;
   logic        ovf;

`ifdef JT900H_PREFETCH_CHK_EN
   localparam logic OV = 1'b1;
`else
   localparam logic OV = 1'b0;
`endif

   jt900h_prefetch #(
      .QD (8),
      .AW (24)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .cen      (cen),
      .jmp      (jmp),
      .jmp_addr (jmp_addr),
      .ram_addr (ram_addr),
      .ram_cs   (ram_cs),
      .ram_dout (ram_dout),
      .ram_ok   (ram_ok),
      .fetched  (fetched),
      .dout     (dout),
      .avail    (avail),
      .pc       (pc),
      .ovf      (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          id;
      logic [31:0] dout;
      logic [2:0]  avail;
      logic [23:0] pc;
      logic        cs;
      logic [23:0] addr;
      logic        ovf;
   } snap_t;

   snap_t       snap_q[$];
   logic [23:0] addr_q[$];
   int          total = 0;
   int          bad   = 0;
   int          snap_id = 0;

   function automatic void chk(input string name, input int id, input logic [31:0] act,
                               input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s #%0d: got %h want %h", name, id, act, exp);
      end
   endfunction

   function automatic logic [15:0] word_at(input logic [23:0] a);
      case (a)
         24'h000100: return 16'h3412;
         24'h000102: return 16'h7856;
         24'h000200: return 16'hBBAA;
         default:    return {a[7:0] + 8'h01, a[7:0]};
      endcase
   endfunction

   task automatic expect_s(input logic [31:0] d, input logic [2:0] av, input logic [23:0] p,
                           input logic cs, input logic [23:0] a, input logic ov);
      snap_t s;
      s.id = snap_id; s.dout = d; s.avail = av; s.pc = p; s.cs = cs; s.addr = a; s.ovf = ov;
      snap_id++;
      snap_q.push_back(s);
   endtask

   task automatic cyc(input logic j, input logic [23:0] ja, input logic ok, input logic [2:0] f);
      jmp      = j;
      jmp_addr = ja;
      ram_ok   = ok;
      fetched  = f;
      ram_dout = word_at(ram_addr);
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input logic [23:0] exp_addr, input logic [2:0] f);
      addr_q.push_back(exp_addr);
      cyc(1'b0, 24'h0, 1'b1, f);
   endtask

   // Output snapshot monitor
   always @(negedge clk) begin
      if (snap_q.size() > 0) begin
         snap_t s;
         s = snap_q.pop_front();
         chk("dout",     s.id, dout,            s.dout);
         chk("avail",    s.id, 32'(avail),      32'(s.avail));
         chk("pc",       s.id, 32'(pc),         32'(s.pc));
         chk("ram_cs",   s.id, 32'(ram_cs),     32'(s.cs));
         chk("ram_addr", s.id, 32'(ram_addr),   32'(s.addr));
         chk("ovf",      s.id, 32'(ovf),        32'(s.ovf));
      end
   end

   // Accepted-read monitor: every captured RAM word must be at the expected address
   always @(negedge clk) begin
      if (!rst && cen && ram_cs && ram_ok && !jmp) begin
         if (addr_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL read_addr: unexpected read at %h, none expected", ram_addr);
         end else begin
            logic [23:0] ea;
            ea = addr_q.pop_front();
            chk("read_addr", 0, 32'(ram_addr), 32'(ea));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state, then jump to 0x100
      expect_s(32'h0, 3'd0, 24'h0, 1'b0, 24'h0, 1'b0);
      cyc(1'b1, 24'h000100, 1'b0, 3'd0);
      // FLUSH: request low, ram_ok ignored
      expect_s(32'h0, 3'd0, 24'h100, 1'b0, 24'h100, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 3'd0);
      expect_s(32'h0, 3'd0, 24'h100, 1'b1, 24'h100, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);
      rd(24'h100, 3'd0);
      expect_s(32'h00003412, 3'd2, 24'h100, 1'b1, 24'h102, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);
      rd(24'h102, 3'd0);
      expect_s(32'h78563412, 3'd4, 24'h100, 1'b1, 24'h104, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);

      // Fill to QD=8, then stall with address frozen
      rd(24'h104, 3'd0);
      rd(24'h106, 3'd0);
      expect_s(32'h78563412, 3'd4, 24'h100, 1'b0, 24'h108, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 3'd0);
      expect_s(32'h78563412, 3'd4, 24'h100, 1'b0, 24'h108, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);
      cyc(1'b0, 24'h0, 1'b0, 3'd4);
      expect_s(32'h07060504, 3'd4, 24'h104, 1'b1, 24'h108, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);

      // Write and retire in the same cycle: 4+2-1=5, then 5+2-3=4 (pointers wrap)
      rd(24'h108, 3'd1);
      expect_s(32'h08070605, 3'd4, 24'h105, 1'b1, 24'h10A, 1'b0);
      rd(24'h10A, 3'd3);
      expect_s(32'h0B0A0908, 3'd4, 24'h108, 1'b1, 24'h10C, 1'b0);

      // Jump to odd address with same-cycle ram_ok and fetched: both discarded
      cyc(1'b1, 24'h000201, 1'b1, 3'd2);
      expect_s(32'h0, 3'd0, 24'h201, 1'b0, 24'h200, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 3'd0);
      expect_s(32'h0, 3'd0, 24'h201, 1'b1, 24'h200, 1'b0);
      rd(24'h200, 3'd0);
      expect_s(32'h000000BB, 3'd1, 24'h201, 1'b1, 24'h202, 1'b0);
      rd(24'h202, 3'd0);
      expect_s(32'h000302BB, 3'd3, 24'h201, 1'b1, 24'h204, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd2);

      // Underrun: count=1, fetched=2 retires one byte
      expect_s(32'h00000003, 3'd1, 24'h203, 1'b1, 24'h204, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd2);
      expect_s(32'h0, 3'd0, 24'h204, 1'b1, 24'h204, OV);
      cyc(1'b0, 24'h0, 1'b0, 3'd3);
      // Empty retire left pc alone; flag sticky
      expect_s(32'h0, 3'd0, 24'h204, 1'b1, 24'h204, OV);
      cen = 1'b0;
      cyc(1'b0, 24'h0, 1'b1, 3'd0);
      cen = 1'b1;
      // cen=0 held everything
      expect_s(32'h0, 3'd0, 24'h204, 1'b1, 24'h204, OV);
      rd(24'h204, 3'd0);
      expect_s(32'h00000504, 3'd2, 24'h204, 1'b1, 24'h206, OV);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);

      // Async reset mid-request
      rst = 1'b1;
      expect_s(32'h0, 3'd0, 24'h0, 1'b0, 24'h0, 1'b0);
      cyc(1'b0, 24'h0, 1'b1, 3'd0);
      rst = 1'b0;
      expect_s(32'h0, 3'd0, 24'h0, 1'b0, 24'h0, 1'b0);
      cyc(1'b0, 24'h0, 1'b0, 3'd0);

      @(negedge clk);
      #1;
      chk("snap_drain", 0, 32'(snap_q.size()), 32'd0);
      chk("addr_drain", 0, 32'(addr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
